// File: rtl/dkong_hiscore_pkg.sv
// Shared types and default constants for the Donkey Kong high-score save/restore controller.
package dkong_hiscore_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_REL
   } state_t;

   typedef enum logic {
      DIR_LOAD,   // host buffer -> CPU RAM
      DIR_DUMP    // CPU RAM -> host buffer
   } dir_t;

   localparam logic [14:0] MODE_ADDR   = 15'h600A;
   localparam logic [14:0] BASE_ADDR   = 15'h6100;
   localparam int          LEN         = 34;
   localparam logic [7:0]  ATTRACT_VAL = 8'h01;
   localparam logic [7:0]  GAME_LO     = 8'h0B;
   localparam logic [7:0]  GAME_HI     = 8'h0D;

endpackage

// File: rtl/dkong_hs_snoop.sv
// Watches CPU writes to the game-mode byte and raises load/dump pending flags.
module dkong_hs_snoop
#(
   parameter logic [14:0] MODE_ADDR   = dkong_hiscore_pkg::MODE_ADDR,
   parameter logic [7:0]  ATTRACT_VAL = dkong_hiscore_pkg::ATTRACT_VAL
)(
   input  logic        clk,
   input  logic        srst,
   input  logic        cpu_mreq_n,
   input  logic        cpu_wr_n,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_d,
   input  logic        load_req,
   input  logic        dump_req,
   input  logic        restore_done,
   input  logic        load_clr,
   input  logic        dump_clr,
   output logic        load_pend,
   output logic        dump_pend
);
   import dkong_hiscore_pkg::*;

   logic wr_prev_q, wr_prev_d;
   logic in_game_q, in_game_d;
   logic load_pend_q, load_pend_d;
   logic dump_pend_q, dump_pend_d;
   logic wr, mode_event, game_val, load_set, dump_set;

   // One event per CPU write (rising edge of the combined strobe), then flag updates.
   // A set in the same cycle as a clear wins so no event is ever lost.
   always_comb begin
      wr          = ~(cpu_mreq_n | cpu_wr_n);
      wr_prev_d   = wr;
      mode_event  = wr && !wr_prev_q && (cpu_addr == MODE_ADDR);
      game_val    = (cpu_d >= GAME_LO) && (cpu_d <= GAME_HI);
      in_game_d   = mode_event ? game_val : in_game_q;
      dump_set    = dump_req || (mode_event && in_game_q && !game_val);
      load_set    = mode_event && (cpu_d == ATTRACT_VAL) && load_req && !restore_done;
      load_pend_d = (load_pend_q && !load_clr) || load_set;
      dump_pend_d = (dump_pend_q && !dump_clr) || dump_set;
   end

   // Snoop state registers.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_prev_q   <= 1'b0;
         in_game_q   <= 1'b0;
         load_pend_q <= 1'b0;
         dump_pend_q <= 1'b0;
      end else begin
         wr_prev_q   <= wr_prev_d;
         in_game_q   <= in_game_d;
         load_pend_q <= load_pend_d;
         dump_pend_q <= dump_pend_d;
      end
   end

   assign load_pend = load_pend_q;
   assign dump_pend = dump_pend_q;

endmodule

// File: rtl/dkong_hiscore_ctrl.sv
// High-score save/restore sequencer: borrows the Z80 RAM and copies the score
// table between CPU RAM and the host buffer in either direction.
module dkong_hiscore_ctrl
#(
   parameter logic [14:0] MODE_ADDR   = dkong_hiscore_pkg::MODE_ADDR,
   parameter logic [14:0] BASE_ADDR   = dkong_hiscore_pkg::BASE_ADDR,
   parameter int          LEN         = dkong_hiscore_pkg::LEN,
   parameter logic [7:0]  ATTRACT_VAL = dkong_hiscore_pkg::ATTRACT_VAL
)(
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_CPU_MREQn,
   input  logic        I_CPU_WRn,
   input  logic [14:0] I_CPU_ADDR,
   input  logic [7:0]  I_CPU_D,
   input  logic        I_LOAD_REQ,
   input  logic        I_DUMP_REQ,
   output logic        O_BUSRQn,
   input  logic        I_BUSAKn,
   output logic        O_BUSY,
   output logic [14:0] O_RAM_ADDR,
   output logic        O_RAM_WE,
   output logic [7:0]  O_RAM_D,
   input  logic [7:0]  I_RAM_Q,
   output logic [5:0]  O_HS_ADDR,
   output logic        O_HS_WE,
   output logic [7:0]  O_HS_D,
   input  logic [7:0]  I_HS_Q,
   output logic        O_DONE
);
   import dkong_hiscore_pkg::*;

   // Index is one bit wider than the host address so idx==LEN is representable at LEN=64.
   localparam logic [6:0] LAST_IDX = 7'(LEN);

   state_t      state_q, state_d;
   dir_t        dir_q, dir_d;
   logic [6:0]  idx_q, idx_d;
   logic [6:0]  prev_idx;
   logic        restore_done_q, restore_done_d;
   logic        busrq_n_q, busrq_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [14:0] ram_addr_q, ram_addr_d;
   logic        ram_we_q, ram_we_d;
   logic [5:0]  hs_addr_q, hs_addr_d;
   logic        hs_we_q, hs_we_d;
   logic        load_pend, dump_pend, load_clr, dump_clr;

   dkong_hs_snoop #(
      .MODE_ADDR   (MODE_ADDR),
      .ATTRACT_VAL (ATTRACT_VAL)
   ) u_snoop (
      .clk          (I_CLK),
      .srst         (I_RESET),
      .cpu_mreq_n   (I_CPU_MREQn),
      .cpu_wr_n     (I_CPU_WRn),
      .cpu_addr     (I_CPU_ADDR),
      .cpu_d        (I_CPU_D),
      .load_req     (I_LOAD_REQ),
      .dump_req     (I_DUMP_REQ),
      .restore_done (restore_done_q),
      .load_clr     (load_clr),
      .dump_clr     (dump_clr),
      .load_pend    (load_pend),
      .dump_pend    (dump_pend)
   );

   // Next-state logic; outputs are derived from the next state so they come straight off flops.
   always_comb begin
      state_d        = state_q;
      dir_d          = dir_q;
      idx_d          = idx_q;
      restore_done_d = restore_done_q;
      load_clr       = 1'b0;
      dump_clr       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_pend) begin
               state_d  = ST_REQ;
               dir_d    = DIR_LOAD;
               load_clr = 1'b1;
            end else if (dump_pend) begin
               state_d  = ST_REQ;
               dir_d    = DIR_DUMP;
               dump_clr = 1'b1;
            end
         end
         ST_REQ: begin
            if (!I_BUSAKn) begin
               state_d = ST_XFER;
               idx_d   = 7'd0;
            end
         end
         ST_XFER: begin
            if (idx_q == LAST_IDX) state_d = ST_REL;
            else                   idx_d   = idx_q + 7'd1;
         end
         ST_REL: begin
            state_d = ST_IDLE;
            if (dir_q == DIR_LOAD) restore_done_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Reads are issued at idx; the write for the same byte lands one cycle later at idx-1.
      prev_idx   = idx_d - 7'd1;
      busrq_n_d  = !((state_d == ST_REQ) || (state_d == ST_XFER));
      busy_d     = (state_d == ST_XFER);
      done_d     = (state_d == ST_REL);
      ram_addr_d = 15'd0;
      ram_we_d   = 1'b0;
      hs_addr_d  = 6'd0;
      hs_we_d    = 1'b0;
      if (state_d == ST_XFER) begin
         if (dir_d == DIR_LOAD) begin
            hs_addr_d = idx_d[5:0];
            if (idx_d != 7'd0) begin
               ram_we_d   = 1'b1;
               ram_addr_d = BASE_ADDR + {8'd0, prev_idx};
            end
         end else begin
            ram_addr_d = BASE_ADDR + {8'd0, idx_d};
            if (idx_d != 7'd0) begin
               hs_we_d   = 1'b1;
               hs_addr_d = prev_idx[5:0];
            end
         end
      end
   end

   // Controller FSM and registered outputs.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q        <= ST_IDLE;
         dir_q          <= DIR_LOAD;
         idx_q          <= 7'd0;
         restore_done_q <= 1'b0;
         busrq_n_q      <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         ram_addr_q     <= 15'd0;
         ram_we_q       <= 1'b0;
         hs_addr_q      <= 6'd0;
         hs_we_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         dir_q          <= dir_d;
         idx_q          <= idx_d;
         restore_done_q <= restore_done_d;
         busrq_n_q      <= busrq_n_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         ram_addr_q     <= ram_addr_d;
         ram_we_q       <= ram_we_d;
         hs_addr_q      <= hs_addr_d;
         hs_we_q        <= hs_we_d;
      end
   end

   // Read data from either side arrives one cycle after its address and is forwarded unregistered.
   assign O_RAM_D    = ram_we_q ? I_HS_Q  : 8'h00;
   assign O_HS_D     = hs_we_q  ? I_RAM_Q : 8'h00;
   assign O_BUSRQn   = busrq_n_q;
   assign O_BUSY     = busy_q;
   assign O_DONE     = done_q;
   assign O_RAM_ADDR = ram_addr_q;
   assign O_RAM_WE   = ram_we_q;
   assign O_HS_ADDR  = hs_addr_q;
   assign O_HS_WE    = hs_we_q;

endmodule

// File: tb/tb_dkong_hiscore_ctrl.sv
// Directed bench for dkong_hiscore_ctrl with RAM / host-buffer models and a Z80 BUSAK model.
module tb_dkong_hiscore_ctrl;

   localparam int          LEN  = 34;
   localparam logic [14:0] BASE = 15'h6100;
   localparam logic [14:0] MODE = 15'h600A;

   logic        clk = 1'b0;
   logic        rst;
   logic        mreq_n, wr_n;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_d;
   logic        load_req, dump_req;
   logic        busrq_n, busak_n;
   logic        busy, ram_we, hs_we, done;
   logic [14:0] ram_addr;
   logic [7:0]  ram_d, ram_q, hs_d, hs_q;
   logic [5:0]  hs_addr;

   always #5 clk = ~clk;

   dkong_hiscore_ctrl dut (
      .I_CLK       (clk),
      .I_RESET     (rst),
      .I_CPU_MREQn (mreq_n),
      .I_CPU_WRn   (wr_n),
      .I_CPU_ADDR  (cpu_addr),
      .I_CPU_D     (cpu_d),
      .I_LOAD_REQ  (load_req),
      .I_DUMP_REQ  (dump_req),
      .O_BUSRQn    (busrq_n),
      .I_BUSAKn    (busak_n),
      .O_BUSY      (busy),
      .O_RAM_ADDR  (ram_addr),
      .O_RAM_WE    (ram_we),
      .O_RAM_D     (ram_d),
      .I_RAM_Q     (ram_q),
      .O_HS_ADDR   (hs_addr),
      .O_HS_WE     (hs_we),
      .O_HS_D      (hs_d),
      .I_HS_Q      (hs_q),
      .O_DONE      (done)
   );

   logic [7:0] ram_mem [0:32767];
   logic [7:0] hs_mem  [0:63];

   // Memory models: synchronous read with one cycle latency, read-before-write.
   always @(posedge clk) begin
      ram_q <= ram_mem[ram_addr];
      hs_q  <= hs_mem[hs_addr];
      if (ram_we) ram_mem[ram_addr] = ram_d;
      if (hs_we)  hs_mem[hs_addr]   = hs_d;
   end

   // Z80 model: acknowledges a bus request after a few cycles, releases when it is dropped.
   initial begin
      int ak_cnt;
      ak_cnt  = 0;
      busak_n = 1'b1;
      forever begin
         @(negedge clk);
         if (busrq_n === 1'b0) begin
            if (ak_cnt >= 3) busak_n = 1'b0;
            ak_cnt++;
         end else begin
            ak_cnt  = 0;
            busak_n = 1'b1;
         end
      end
   end

   int          ram_we_cnt, hs_we_cnt, done_cnt, req_cnt, busy_cnt, first_kind;
   logic [14:0] ram_wmin, ram_wmax;
   logic [5:0]  hs_wmax;
   logic        busrq_prev = 1'b1;

   // Activity monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         ram_we_cnt++;
         if (ram_addr < ram_wmin) ram_wmin = ram_addr;
         if (ram_addr > ram_wmax) ram_wmax = ram_addr;
         if (first_kind == 0) first_kind = 1;
      end
      if (hs_we === 1'b1) begin
         hs_we_cnt++;
         if (hs_addr > hs_wmax) hs_wmax = hs_addr;
         if (first_kind == 0) first_kind = 2;
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (busrq_prev && (busrq_n === 1'b0)) req_cnt++;
      busrq_prev = busrq_n;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   function automatic logic [7:0] pat_a(input int i);
      return 8'(8'h5A + i * 3);
   endfunction

   function automatic logic [7:0] pat_b(input int i);
      return 8'hC3 ^ 8'(i);
   endfunction

   task automatic clear_counts();
      @(posedge clk);
      #1;
      ram_we_cnt = 0; hs_we_cnt = 0; done_cnt = 0; req_cnt = 0; busy_cnt = 0; first_kind = 0;
      ram_wmin = 15'h7FFF; ram_wmax = 15'h0000; hs_wmax = 6'd0;
   endtask

   task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      cpu_addr = a; cpu_d = d; mreq_n = 1'b0; wr_n = 1'b0;
      repeat (hold) @(negedge clk);
      mreq_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_done(input int target, input string tag);
      int n;
      n = 0;
      while ((done_cnt < target) && (n < 400)) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(done_cnt >= target), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int errs;
      int n;
      rst = 1'b1; mreq_n = 1'b1; wr_n = 1'b1; cpu_addr = '0; cpu_d = '0;
      load_req = 1'b0; dump_req = 1'b0;
      for (int i = 0; i < 32768; i++) ram_mem[i] = 8'h00;
      for (int i = 0; i < 64; i++) hs_mem[i] = pat_a(i);
      ram_q = 8'h00; hs_q = 8'h00;
      clear_counts();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busrq_n", 32'(busrq_n), 32'd1);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_ram_we",  32'(ram_we),  32'd0);
      check("rst_hs_we",   32'(hs_we),   32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_hs_addr", 32'(hs_addr), 32'd0);
      check("rst_data",    32'({ram_d, hs_d}), 32'd0);
      rst = 1'b0;

      // Restore: attract-mode write with a loaded host buffer
      clear_counts();
      load_req = 1'b1;
      cpu_write(MODE, 8'h01, 1);
      wait_done(1, "load_finished");
      errs = 0;
      for (int i = 0; i < LEN; i++) if (ram_mem[BASE + 15'(i)] !== pat_a(i)) errs++;
      check("load_ram_we_cnt", 32'(ram_we_cnt), 32'd34);
      check("load_hs_we_cnt",  32'(hs_we_cnt),  32'd0);
      check("load_done_cnt",   32'(done_cnt),   32'd1);
      check("load_req_cnt",    32'(req_cnt),    32'd1);
      check("load_busy_cycles", 32'(busy_cnt),  32'd35);
      check("load_addr_min",   32'(ram_wmin),   32'h6100);
      check("load_addr_max",   32'(ram_wmax),   32'h6121);
      check("load_data_errs",  32'(errs),       32'd0);
      check("load_below_base", 32'(ram_mem[15'h60FF]), 32'd0);
      check("load_past_end",   32'(ram_mem[15'h6122]), 32'd0);
      clear_counts();
      cpu_write(MODE, 8'h01, 1);
      repeat (40) @(negedge clk);
      check("reload_ignored_done", 32'(done_cnt), 32'd0);
      check("reload_ignored_req",  32'(req_cnt),  32'd0);
      load_req = 1'b0;

      // Save: leaving game mode
      for (int i = 0; i < LEN; i++) ram_mem[BASE + 15'(i)] = pat_b(i);
      for (int i = 0; i < 64; i++) hs_mem[i] = 8'hEE;
      clear_counts();
      cpu_write(MODE, 8'h0C, 1);
      cpu_write(MODE, 8'h00, 1);
      wait_done(1, "dump_finished");
      errs = 0;
      for (int i = 0; i < LEN; i++) if (hs_mem[i] !== pat_b(i)) errs++;
      check("dump_hs_we_cnt",  32'(hs_we_cnt),  32'd34);
      check("dump_ram_we_cnt", 32'(ram_we_cnt), 32'd0);
      check("dump_done_cnt",   32'(done_cnt),   32'd1);
      check("dump_hs_addr_max", 32'(hs_wmax),   32'd33);
      check("dump_data_errs",  32'(errs),       32'd0);
      check("dump_first_byte", 32'(hs_mem[0]),  32'hC3);
      check("dump_past_end",   32'(hs_mem[34]), 32'hEE);

      // Mode changes that stay within game values never trigger a save
      clear_counts();
      cpu_write(MODE, 8'h0B, 1);
      cpu_write(MODE, 8'h0D, 1);
      repeat (40) @(negedge clk);
      check("ingame_no_dump_done", 32'(done_cnt), 32'd0);
      check("ingame_no_dump_req",  32'(req_cnt),  32'd0);

      // Long write strobe is one event
      for (int i = 0; i < 64; i++) hs_mem[i] = 8'hEE;
      clear_counts();
      cpu_write(MODE, 8'h00, 4);
      wait_done(1, "long_strobe_finished");
      repeat (40) @(negedge clk);
      errs = 0;
      for (int i = 0; i < LEN; i++) if (hs_mem[i] !== pat_b(i)) errs++;
      check("long_strobe_done", 32'(done_cnt),  32'd1);
      check("long_strobe_req",  32'(req_cnt),   32'd1);
      check("long_strobe_hs_we", 32'(hs_we_cnt), 32'd34);
      check("long_strobe_errs", 32'(errs),      32'd0);

      // Load and dump pending together: load goes first
      do_reset();
      for (int i = 0; i < 64; i++) hs_mem[i] = pat_a(i);
      clear_counts();
      load_req = 1'b1;
      cpu_write(MODE, 8'h0C, 1);
      cpu_write(MODE, 8'h01, 1);
      wait_done(2, "both_finished");
      errs = 0;
      for (int i = 0; i < LEN; i++) if (ram_mem[BASE + 15'(i)] !== pat_a(i)) errs++;
      check("both_done_cnt",   32'(done_cnt),   32'd2);
      check("both_req_cnt",    32'(req_cnt),    32'd2);
      check("both_load_first", 32'(first_kind), 32'd1);
      check("both_ram_we_cnt", 32'(ram_we_cnt), 32'd34);
      check("both_hs_we_cnt",  32'(hs_we_cnt),  32'd34);
      check("both_ram_errs",   32'(errs),       32'd0);
      load_req = 1'b0;

      // Reset in the middle of a dump
      do_reset();
      clear_counts();
      @(negedge clk);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      n = 0;
      while (!((busy === 1'b1) && (ram_addr == BASE + 15'd10)) && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      check("midxfer_reached", 32'(n < 200), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midxfer_busrq_n", 32'(busrq_n), 32'd1);
      check("midxfer_busy",    32'(busy),    32'd0);
      check("midxfer_we",      32'({ram_we, hs_we}), 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midxfer_hs_we_cnt", 32'(hs_we_cnt), 32'd10);
      check("midxfer_no_done",   32'(done_cnt),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
